sign_word_packer: RTL



---
 rtl/sign_word_packer.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/sign_word_packer.sv
// Packs the MSB-first sign bit stream into W-bit words held in a DEPTH-entry FIFO; a pushed word reaches out_* one cycle later when the FIFO is empty.
// The bit source cannot be stalled: a word pushed into a full FIFO with no pop is dropped and sets sticky overflow. Define SIGN_WORD_PACKER_PARITY_EN to add out_parity.

module sign_word_packer_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             push,
   input  logic [WIDTH-1:0] push_dat,
   input  logic             pop,
   output logic [WIDTH-1:0] head_dat,
   output logic             vld,
   output logic             full
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]   CNT_DEPTH = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE   = AW'(1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    rd_ptr_inc;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign vld        = (count != '0);
   assign full       = (count == CNT_DEPTH);
   assign do_pop     = en & pop & vld;
   assign do_push    = en & push & (~full | do_pop);
   assign rd_ptr_inc = rd_ptr + PTR_ONE;

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_dat;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         head_dat <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr_inc;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
         // Head is a register copy of mem[rd_ptr] so it keeps its last value once the FIFO drains.
         if (do_pop) begin
            if (count > CNT_ONE) begin
               head_dat <= mem[rd_ptr_inc];
            end else if (do_push) begin
               head_dat <= push_dat;
            end
         end else if (do_push && !vld) begin
            head_dat <= push_dat;
         end
      end
   end
endmodule

module sign_word_packer #(
   parameter int W     = 32,
   parameter int DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clk_en,
   input  logic                 sign_in,
   input  logic                 sign_en,
   input  logic                 flush,
   input  logic                 out_ready,
   output logic                 out_valid,
   output logic [W-1:0]         out_data,
   output logic [$clog2(W):0]   out_bits,
   output logic                 out_last,
   output logic                 overflow
`ifdef SIGN_WORD_PACKER_PARITY_EN
   ,
   output logic                 out_parity
`endif
);
   localparam int CW = $clog2(W) + 1;
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_W    = CW'(W);
   localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
`ifdef SIGN_WORD_PACKER_PARITY_EN
   localparam int EW = W + CW + 2;
`else
   localparam int EW = W + CW + 1;
`endif

   logic [W-1:0]  acc;
   logic [W-1:0]  acc_nxt;
   logic [W-1:0]  word;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nxt;
   logic          take;
   logic          close;
   logic          full_word;
   logic          push;
   logic          pop;
   logic          fifo_full;
   logic [EW-1:0] push_dat;
   logic [EW-1:0] head_dat;

   assign take      = clk_en & sign_en;
   assign close     = clk_en & flush;
   assign full_word = take && (cnt == CNT_LAST);
   assign push      = full_word | close;
   assign pop       = out_valid & out_ready;

   always_comb begin
      acc_nxt = acc;
      cnt_nxt = cnt;
      if (take) begin
         acc_nxt = {acc[W-2:0], sign_in};
         cnt_nxt = cnt + CNT_ONE;
      end
   end

   // Left-align: the shift is zero for a full word and clears everything for the cnt==0 marker.
   assign word = acc_nxt << (CNT_W - cnt_nxt);

`ifdef SIGN_WORD_PACKER_PARITY_EN
   assign push_dat = {^word, close, cnt_nxt, word};
   assign {out_parity, out_last, out_bits, out_data} = head_dat;
`else
   assign push_dat = {close, cnt_nxt, word};
   assign {out_last, out_bits, out_data} = head_dat;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         acc      <= '0;
         cnt      <= '0;
         overflow <= 1'b0;
      end else if (clk_en) begin
         acc <= acc_nxt;
         cnt <= push ? '0 : cnt_nxt;
         if (push && fifo_full && !pop) begin
            overflow <= 1'b1;
         end
      end
   end

   sign_word_packer_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .en       (clk_en),
      .push     (push),
      .push_dat (push_dat),
      .pop      (pop),
      .head_dat (head_dat),
      .vld      (out_valid),
      .full     (fifo_full)
   );
endmodule
